// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared constants for the keypad scanner and its downstream key register:
// the NO_KEY code, the scanner state encoding and the row drive patterns.
package keypad_pkg;

    localparam logic [4:0] NO_KEY = 5'b10000;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    // Active-low one-cold row drive: index 0 -> 4'b1110 ... index 3 -> 4'b0111.
    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce
// Saturating stable-cycle counter. Counts rising edges on which match is
// high; clear or a missed match returns the count to zero. done is high
// once CYCLES consecutive matches have been seen and stays high while
// match holds.
//   Clock  in   system clock
//   Reset  in   synchronous active-high reset
//   clear  in   force count to zero
//   match  in   current cycle is stable
//   done   out  count has reached CYCLES
module keypad_debounce #(
    parameter int unsigned CYCLES = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic match,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] count;

    assign done = (count == CNT_W'(CYCLES));

    always_ff @(posedge Clock) begin
        if (Reset || clear || !match) begin
            count <= '0;
        end else if (!done) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// 4x4 matrix keypad scanner: walks an active-low row drive, debounces a
// press, reports it once as a registered one-cycle strobe, then waits for
// a debounced release before scanning again.
//   Clock      in   system clock
//   Reset      in   synchronous active-high reset
//   Row[3:0]   out  row drive, active-low, one bit low
//   Col[3:0]   in   column sense, active-low, pre-synchronised
//   Key_code   out  {invalid, code[3:0]}, NO_KEY unless reporting
//   Key_valid  out  one-cycle report strobe
//
// state       | meaning
// ST_SCAN     | walk rows, wait for any low column
// ST_DEBOUNCE | row frozen, column pattern must stay stable
// ST_EMIT     | one cycle, Key_valid/Key_code presented
// ST_HOLD     | row frozen, wait for a stable all-high release
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    output logic [3:0] Row,
    input  logic [3:0] Col,
    output logic [4:0] Key_code,
    output logic       Key_valid
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    state_t           state, state_next;
    logic [1:0]       row_idx;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       col_latch;
    logic [1:0]       col_idx;
    logic             col_active;
    logic             db_clear, db_match, db_done;

    assign col_active = (Col != 4'b1111);
    assign Row        = row_drive(row_idx);

    keypad_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .Clock(Clock),
        .Reset(Reset),
        .clear(db_clear),
        .match(db_match),
        .done (db_done)
    );

    // Multi-key press on one row resolves to the lowest column.
    always_comb begin
        col_idx = 2'd3;
        if (!col_latch[0])      col_idx = 2'd0;
        else if (!col_latch[1]) col_idx = 2'd1;
        else if (!col_latch[2]) col_idx = 2'd2;
    end

    always_comb begin
        state_next = state;
        db_clear   = 1'b0;
        db_match   = 1'b0;
        case (state)
            ST_SCAN: begin
                db_clear = 1'b1;
                if (col_active) state_next = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                db_match = (Col == col_latch);
                if (!db_match)   state_next = ST_SCAN;
                else if (db_done) state_next = ST_EMIT;
            end
            ST_EMIT: begin
                db_clear   = 1'b1;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                db_match = !col_active;
                if (db_done) state_next = ST_SCAN;
            end
            default: state_next = ST_SCAN;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_SCAN;
            row_idx   <= 2'd0;
            div_cnt   <= '0;
            col_latch <= 4'b1111;
            Key_valid <= 1'b0;
            Key_code  <= NO_KEY;
        end else begin
            state     <= state_next;
            Key_valid <= (state_next == ST_EMIT);
            Key_code  <= (state_next == ST_EMIT) ? {1'b0, row_idx, col_idx} : NO_KEY;

            if (state == ST_SCAN && state_next == ST_DEBOUNCE) begin
                col_latch <= Col;
            end

            // Divider only runs while scanning; any frozen period restarts
            // the dwell on the row scanning resumes at.
            if (state == ST_SCAN && state_next == ST_SCAN) begin
                if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                    div_cnt <= '0;
                    row_idx <= row_idx + 2'd1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                div_cnt <= '0;
            end

            if (state == ST_HOLD && state_next == ST_SCAN) begin
                row_idx <= row_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Scoreboard bench for keypad_scanner at SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// Each press pushes its expected code and strobe cycle; a negedge monitor
// pops and compares on every Key_valid and checks the idle code otherwise.
module tb_keypad_scanner;

    logic       Clock;
    logic       Reset;
    logic [3:0] Row;
    logic [3:0] Col;
    logic [4:0] Key_code;
    logic       Key_valid;

    typedef struct {
        logic [4:0] code;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;

    localparam logic [4:0] IDLE_CODE = 5'b10000;
    logic [3:0] pats [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Row      (Row),
        .Col      (Col),
        .Key_code (Key_code),
        .Key_valid(Key_valid)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    always @(negedge Clock) begin
        if (mon_en) begin
            if (Key_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", Key_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("key_code", Key_code, e.code);
                    check("strobe_cycle", cyc, e.due);
                end
            end else begin
                check("idle_code", Key_code, IDLE_CODE);
            end
        end
    end

    task automatic wait_row(input logic [3:0] target);
        int n = 0;
        while (Row !== target && n < 40) begin
            @(negedge Clock);
            n++;
        end
        check("wait_row", Row, target);
    endtask

    // Called at a negedge with the target row showing; strobe lands on the
    // tenth following negedge (first sampling edge + 9).
    task automatic press(input logic [3:0] col, input logic [4:0] code);
        exp_t e;
        e.code = code;
        e.due  = cyc + 10;
        sb.push_back(e);
        Col = col;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        Reset = 1'b1;
        Col   = 4'b1111;
        idle(3);
        check("rst_row",   Row,       4'b1110);
        check("rst_valid", Key_valid, 0);
        check("rst_code",  Key_code,  IDLE_CODE);
        mon_en = 1'b1;
        Reset  = 1'b0;

        // Free scan: four cycles per row.
        for (int k = 0; k < 40; k++) begin
            check("scan_row", Row, pats[(k / 4) % 4]);
            @(negedge Clock);
        end

        // Single press on row 1, column 2, held long.
        wait_row(4'b1101);
        press(4'b1011, 5'b00110);
        idle(110);
        check("hold_row_frozen", Row, 4'b1101);
        check("hold_sb_empty", sb.size(), 0);
        Col = 4'b1111;
        idle(12);

        // Bounce shorter than the debounce window.
        wait_row(4'b1110);
        Col = 4'b1110;
        idle(5);
        Col = 4'b1111;
        begin
            int n = 0;
            while (Row === 4'b1110 && n < 10) begin
                @(negedge Clock);
                n++;
            end
        end
        check("bounce_resume", Row, 4'b1101);

        // Two keys on row 3: lowest column wins.
        wait_row(4'b0111);
        press(4'b0101, 5'b01101);
        idle(20);
        Col = 4'b1111;
        idle(12);

        // Short release inside HOLD must not re-arm.
        wait_row(4'b1011);
        press(4'b0111, 5'b01011);
        idle(15);
        Col = 4'b1111;
        idle(7);
        Col = 4'b0111;
        idle(20);
        check("short_release_frozen", Row, 4'b1011);
        Col = 4'b1111;
        idle(12);
        wait_row(4'b1110);
        press(4'b1101, 5'b00001);
        idle(15);
        Col = 4'b1111;
        idle(12);
        check("after_release_sb", sb.size(), 0);

        // Reset three cycles into DEBOUNCE.
        wait_row(4'b1101);
        Col = 4'b1110;
        idle(3);
        Reset = 1'b1;
        idle(1);
        check("rst_db_row",   Row,       4'b1110);
        check("rst_db_valid", Key_valid, 0);
        check("rst_db_code",  Key_code,  IDLE_CODE);
        Col   = 4'b1111;
        Reset = 1'b0;
        idle(2);

        // Reset during EMIT.
        wait_row(4'b0111);
        press(4'b1110, 5'b01100);
        begin
            int n = 0;
            while (!Key_valid && n < 20) begin
                @(negedge Clock);
                n++;
            end
        end
        check("emit_seen", Key_valid, 1);
        Reset = 1'b1;
        Col   = 4'b1111;
        idle(1);
        check("rst_emit_valid", Key_valid, 0);
        check("rst_emit_row",   Row,       4'b1110);
        check("rst_emit_code",  Key_code,  IDLE_CODE);
        Reset = 1'b0;
        idle(10);

        check("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each row stays driven during scanning, range 2..255.
REQ-002 Parameter DEBOUNCE_CYCLES, default 8: consecutive stable cycles required to accept a press or a release, range 2..255.
REQ-003 Clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Row  output  4  keypad row drive, active-low, exactly one bit low at a time.
REQ-006 Col  input  4  keypad column sense, active-low, already synchronised externally.
REQ-007 Key_code  output  5  {invalid, code[3:0]}; equals NO_KEY (5'b10000) unless a key is being reported.
REQ-008 Key_valid  output  1  one-cycle strobe, wired to the downstream register's load enable.

Function
REQ-009 States: SCAN, DEBOUNCE, EMIT, HOLD.
REQ-010 SCAN: Row walks 4'b1110 -> 4'b1101 -> 4'b1011 -> 4'b0111 -> 4'b1110, advancing every SCAN_DIV cycles.
REQ-011 SCAN -> DEBOUNCE on the first cycle Col != 4'b1111; latch the current row index r and the column pattern; freeze Row.
REQ-012 DEBOUNCE: count cycles while Col equals the latched pattern; reaching DEBOUNCE_CYCLES -> EMIT.
REQ-013 DEBOUNCE: any Col change -> SCAN at the same row, counter cleared, nothing emitted.
REQ-014 Column index c = lowest-numbered low bit of the latched pattern (multi-key press resolves to lowest column).
REQ-015 EMIT lasts exactly one cycle: Key_valid = 1, Key_code = {1'b0, r[1:0], c[1:0]} (code = 4*r + c); then -> HOLD.
REQ-016 Key_code and Key_valid are registered outputs; the strobe appears DEBOUNCE_CYCLES+1 cycles after the first cycle Col shows the press.
REQ-017 HOLD: Row stays frozen; count cycles with Col == 4'b1111; any low column clears the count; reaching DEBOUNCE_CYCLES -> SCAN, scanning resumes at the next row.
REQ-018 No further Key_valid until a full debounced release has occurred; holding a key yields exactly one report.
REQ-019 Outside EMIT: Key_valid = 0 and Key_code = 5'b10000.
REQ-020 Counters saturate, never wrap; widths are sized from the parameters.

Reset
REQ-021 Reset asserted on a rising edge: state = SCAN, Row = 4'b1110, row index = 0, all counters = 0, Key_valid = 0, Key_code = 5'b10000.
REQ-022 Reset overrides every state, including mid-DEBOUNCE and mid-EMIT; no strobe is produced in the cycle after reset.

Structure
REQ-023 A shared package holds NO_KEY = 5'b10000, the state encoding, and the row drive patterns; the downstream register uses the same NO_KEY constant.
REQ-024 One sub-module, keypad_debounce: a saturating stable-cycle counter with clear, match, and done outputs, instantiated once and shared by DEBOUNCE and HOLD.
REQ-025 The FSM, row walker, and priority encoder stay in keypad_scanner.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-026 Reset, Col=4'b1111 for 40 cycles -> Row cycles through the 4 patterns every 4 cycles, Key_valid never set, Key_code=5'b10000.
REQ-027 Col=4'b1011 held while Row=4'b1101 -> exactly one Key_valid pulse 9 cycles later, with Key_code=5'b00110; holding for 100 more cycles gives no second pulse.
REQ-028 Col=4'b1110 for 5 cycles then 4'b1111 (bounce) -> no Key_valid; scanning resumes.
REQ-029 Col=4'b0101 with Row=4'b0111 -> Key_code=5'b01101 (lowest column 1 wins).
REQ-030 Release shorter than 8 cycles (7 high, then low) inside HOLD -> no new report; a full 8-cycle release followed by a new press -> one new report.
REQ-031 Reset asserted 3 cycles into DEBOUNCE -> next cycle shows state SCAN, Row=4'b1110, Key_code=5'b10000, no strobe.
